// File: rtl/conquest_vector_player.sv
// Stimulus vector sequencer: replays a loaded program of vectors, each held
// for a per-entry count, with loop mode, wrap counter and mid-run abort.
//
// Ports:
//   sys_clk, sys_rst        clock, async active-high reset
//   load_en/addr/data/hold  program entry write (any state)
//   start, stop, loop_en    playback control
//   last_addr               final program entry, latched at start
//   vec_out, vec_valid, pc  registered playback outputs
//   loop_cnt                completed wraps, saturating
//   done                    one-cycle pulse on normal completion
module conquest_vector_player #(
  parameter int VEC_W  = 10,
  parameter int ADDR_W = 4,
  parameter int HOLD_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [VEC_W-1:0]  load_data,
  input  logic [HOLD_W-1:0] load_hold,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [VEC_W-1:0]  vec_out,
  output logic              vec_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        loop_cnt,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [VEC_W-1:0]  mem_vec  [DEPTH];
  logic [HOLD_W-1:0] mem_hold [DEPTH];

  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [ADDR_W-1:0] last_q, last_n;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic [VEC_W-1:0]  vec_n;
  logic [7:0]        loop_n;
  logic              valid_n;
  logic              done_n;

  // Program storage is deliberately not reset so it survives sys_rst.
  always_ff @(posedge sys_clk) begin
    if (load_en) begin
      mem_vec[load_addr]  <= load_data;
      mem_hold[load_addr] <= load_hold;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      pc        <= '0;
      loop_cnt  <= '0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      last_q    <= '0;
    end else begin
      state     <= state_n;
      vec_out   <= vec_n;
      vec_valid <= valid_n;
      pc        <= pc_n;
      loop_cnt  <= loop_n;
      done      <= done_n;
      hold_cnt  <= hold_n;
      last_q    <= last_n;
    end
  end

  assign pc_inc = pc + 1'b1;

  always_comb begin
    state_n = state;
    vec_n   = vec_out;
    valid_n = vec_valid;
    pc_n    = pc;
    loop_n  = loop_cnt;
    done_n  = 1'b0;
    hold_n  = hold_cnt;
    last_n  = last_q;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          last_n  = last_addr;
          pc_n    = '0;
          vec_n   = mem_vec[0];
          hold_n  = mem_hold[0];
          valid_n = 1'b1;
          loop_n  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (hold_cnt != '0) begin
          hold_n = hold_cnt - 1'b1;
        end else if (pc != last_q) begin
          pc_n   = pc_inc;
          vec_n  = mem_vec[pc_inc];
          hold_n = mem_hold[pc_inc];
        end else if (loop_en) begin
          pc_n   = '0;
          vec_n  = mem_vec[0];
          hold_n = mem_hold[0];
          if (loop_cnt != 8'hFF) loop_n = loop_cnt + 8'd1;
        end else begin
          state_n = IDLE;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
